// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the multi-cycle magnitude comparator.
// Result vectors are packed as {lt, eq, gt}.
package cmp_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCmp
  } cmp_state_e;

  localparam logic [2:0] ResNone = 3'b000;
  localparam logic [2:0] ResLt   = 3'b100;
  localparam logic [2:0] ResEq   = 3'b010;
  localparam logic [2:0] ResGt   = 3'b001;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// Combinational unsigned comparator for one CHUNK-bit slice.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks operands MS chunk first, one chunk per clock,
// stopping at the first differing chunk. Signed mode uses offset-binary so the walk is unsigned.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int NCHUNK = nchunk(WIDTH, CHUNK),
  localparam int CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH < CHUNK) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("WIDTH must be a non-zero multiple of CHUNK");
  end

  cmp_state_e       r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [IW-1:0]    r_idx, w_idx_d;
  logic [2:0]       r_res, w_res_d;
  logic [CW-1:0]    r_cycles, w_cycles_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;

  logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
  logic             w_lt, w_eq, w_gt;

  assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[int'(r_idx)*CHUNK +: CHUNK];

  chunk_compare #(
    .CHUNK(CHUNK)
  ) u_chunk_compare (
    .x (w_a_chunk),
    .y (w_b_chunk),
    .lt(w_lt),
    .eq(w_eq),
    .gt(w_gt)
  );

  always_comb begin
    w_state_d  = r_state;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_idx_d    = r_idx;
    w_res_d    = r_res;
    w_cycles_d = r_cycles;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          w_a_d               = a;
          w_b_d               = b;
          w_a_d[WIDTH-1]      = a[WIDTH-1] ^ signed_mode;
          w_b_d[WIDTH-1]      = b[WIDTH-1] ^ signed_mode;
          w_idx_d             = IW'(NCHUNK - 1);
          w_res_d             = ResNone;
          w_cycles_d          = '0;
          w_busy_d            = 1'b1;
          w_state_d           = StCmp;
        end
      end
      StCmp: begin
        w_cycles_d = r_cycles + CW'(1);
        if (!w_eq) begin
          w_res_d   = w_lt ? ResLt : ResGt;
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end else if (r_idx == '0) begin
          w_res_d   = ResEq;
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end else begin
          w_idx_d = r_idx - IW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_res    <= ResNone;
      r_cycles <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_idx    <= w_idx_d;
      r_res    <= w_res_d;
      r_cycles <= w_cycles_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign lt     = r_res[2];
  assign eq     = r_res[1];
  assign gt     = r_res[0];
  assign cycles = r_cycles;

  // Unused by design: gt from the chunk comparator is implied by !lt && !eq.
  logic w_unused;
  assign w_unused = w_gt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, lt, eq, gt;
  logic [2:0]  cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .lt         (lt),
    .eq         (eq),
    .gt         (gt),
    .cycles     (cycles)
  );

  // Drives one start pulse; returns at the negedge just after the accept edge.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic sm);
    @(negedge clk);
    a = va;
    b = vb;
    signed_mode = sm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; lat equals k for a normal start_op.
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, lt, eq, gt, cycles} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b res=%b cycles=%0d, required all 0",
               busy, done, {lt, eq, gt}, cycles);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_equal();
    int lat; bit to;
    start_op(16'h1234, 16'h1234, 1'b0);
    checks++;
    if (busy !== 1'b1 || {lt, eq, gt} !== 3'b000 || done !== 1'b0) begin
      failures++;
      $display("FAIL eq_inflight: got busy=%b done=%b res=%b, required busy=1 done=0 res=000",
               busy, done, {lt, eq, gt});
    end
    wait_done(lat, to);
    checks++;
    if (to || lat != 4) begin
      failures++;
      $display("FAIL eq_latency: got %0d (timeout=%0b), required 4", lat, to);
    end
    checks++;
    if ({lt, eq, gt} !== 3'b010 || cycles !== 3'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL eq_result: got res=%b cycles=%0d busy=%b, required res=010 cycles=4 busy=0",
               {lt, eq, gt}, cycles, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL eq_done_pulse: got done=%b in cycle after done, required 0", done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({lt, eq, gt} !== 3'b010 || cycles !== 3'd4) begin
      failures++;
      $display("FAIL eq_hold: got res=%b cycles=%0d, required res=010 cycles=4",
               {lt, eq, gt}, cycles);
    end
  endtask

  task automatic test_early_exit();
    int lat; bit to;
    start_op(16'hA000, 16'h3000, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != 1 || {lt, eq, gt} !== 3'b001 || cycles !== 3'd1) begin
      failures++;
      $display("FAIL gt_early: got lat=%0d res=%b cycles=%0d, required lat=1 res=001 cycles=1",
               lat, {lt, eq, gt}, cycles);
    end
  endtask

  task automatic test_signed();
    int lat; bit to;
    start_op(16'hFFFF, 16'h0001, 1'b1);
    wait_done(lat, to);
    checks++;
    if (to || {lt, eq, gt} !== 3'b100 || cycles !== 3'd1) begin
      failures++;
      $display("FAIL signed_neg1_vs_1: got res=%b cycles=%0d, required res=100 cycles=1",
               {lt, eq, gt}, cycles);
    end
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || {lt, eq, gt} !== 3'b001 || cycles !== 3'd1) begin
      failures++;
      $display("FAIL unsigned_ffff_vs_1: got res=%b cycles=%0d, required res=001 cycles=1",
               {lt, eq, gt}, cycles);
    end
    start_op(16'h0012, 16'h0013, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != 4 || {lt, eq, gt} !== 3'b100 || cycles !== 3'd4) begin
      failures++;
      $display("FAIL lt_last_chunk: got lat=%0d res=%b cycles=%0d, required lat=4 res=100 cycles=4",
               lat, {lt, eq, gt}, cycles);
    end
    start_op(16'h8000, 16'h7FFF, 1'b1);
    wait_done(lat, to);
    checks++;
    if (to || {lt, eq, gt} !== 3'b100 || cycles !== 3'd1) begin
      failures++;
      $display("FAIL signed_min_vs_max: got res=%b cycles=%0d, required res=100 cycles=1",
               {lt, eq, gt}, cycles);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; bit to;
    start_op(16'h0013, 16'h0012, 1'b0);
    a = 16'h0000;
    b = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, to);
    checks++;
    if (to || lat + 1 != 4 || {lt, eq, gt} !== 3'b001 || cycles !== 3'd4) begin
      failures++;
      $display("FAIL busy_ignore: got lat=%0d res=%b cycles=%0d, required lat=4 res=001 cycles=4",
               lat + 1, {lt, eq, gt}, cycles);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    start_op(16'hA000, 16'h3000, 1'b0);
    wait_done(lat, to);
    a = 16'h0001;
    b = 16'h0000;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {lt, eq, gt} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b res=%b, required busy=1 done=0 res=000",
               busy, done, {lt, eq, gt});
    end
    wait_done(lat, to);
    checks++;
    if (to || lat != 4 || {lt, eq, gt} !== 3'b001 || cycles !== 3'd4) begin
      failures++;
      $display("FAIL b2b_result: got lat=%0d res=%b cycles=%0d, required lat=4 res=001 cycles=4",
               lat, {lt, eq, gt}, cycles);
    end
  endtask

  task automatic test_reset_midop();
    int lat; bit to; bit saw_done;
    start_op(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, lt, eq, gt, cycles} !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: got busy=%b done=%b res=%b cycles=%0d, required all 0",
               busy, done, {lt, eq, gt}, cycles);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_no_done: got done pulse after abort, required none");
    end
    start_op(16'h5555, 16'h5555, 1'b0);
    wait_done(lat, to);
    checks++;
    if (to || lat != 4 || {lt, eq, gt} !== 3'b010 || cycles !== 3'd4) begin
      failures++;
      $display("FAIL post_reset_eq: got lat=%0d res=%b cycles=%0d, required lat=4 res=010 cycles=4",
               lat, {lt, eq, gt}, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_early_exit();
    test_signed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands most-significant chunk first, CHUNK bits per clock, and stops early at the first differing chunk. Unsigned or two's-complement signed mode is selected per request. It replaces single-cycle fixed 4-bit comparison where operand width would make one wide compare the critical path. Results come back through a start/busy/done handshake, with a count of chunks examined.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of CHUNK, ≥ CHUNK
- CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when busy=0
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  comparison in progress
- done  out  1  one-cycle pulse; lt/eq/gt/cycles valid from this cycle
- lt  out  1  A < B
- eq  out  1  A == B
- gt  out  1  A > B
- cycles  out  $clog2(NCHUNK+1)  chunks examined for the last result, 1..NCHUNK

## Operation
- States: IDLE, CMP.
- IDLE with start=1 (accept edge E0):
  - Capture a, b and signed_mode into internal registers.
  - In signed mode, invert the MSB of both captured operands (offset-binary), so the rest of the compare is unsigned.
  - Set idx = NCHUNK-1 and clear lt/eq/gt/cycles to 0.
  - Set busy=1 and go to CMP.
- CMP, each cycle: compare chunk idx of A and B using the chunk comparator; cycles increments by 1.
  - Chunks differ: set lt or gt, pulse done, clear busy, go to IDLE.
  - Chunks equal and idx==0: set eq=1, pulse done, clear busy, go to IDLE.
  - Chunks equal and idx>0: idx decrements; stay in CMP.
- Exactly one of lt/eq/gt is 1 after done. All three are 0 between acceptance and done.
- Results and cycles hold until the next accepted start.
- start while busy=1 is ignored. a, b and signed_mode may change freely while busy.
- Reset behaviour:
  - Reset at any time: state IDLE, busy=0, done=0, lt=eq=gt=0, cycles=0.
  - Reset mid-operation aborts the compare; no done is produced.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: done is high in the cycle after edge E_k, where k = 1 + (number of equal leading chunks).
  - Minimum k = 1 (the top chunks differ).
  - Maximum k = NCHUNK (equal operands, or the difference lies only in chunk 0).
  - cycles = k.
- busy is high from after E0 through after E_(k-1). It is low in the done cycle.
- Back-to-back: start high in the done cycle is accepted at that edge. Throughput is one result per k+1 cycles minimum.
- done must never be high for two consecutive cycles.

## Structure
- Package cmp_pkg holds:
  - state enum (IDLE, CMP)
  - result encoding constants
  - function nchunk(WIDTH, CHUNK)
- The elaboration-time check that WIDTH % CHUNK == 0 lives in the top module.
- Sub-module chunk_compare: combinational, parameter CHUNK, inputs x and y, outputs lt/eq/gt. It is the direct generalisation of the existing 4-bit comparator and is instantiated once. The top module muxes chunk idx into it.

## Test plan
Default parameters (WIDTH=16, CHUNK=4):
- Unsigned, a=0x1234, b=0x1234 → eq=1, lt=gt=0, done 4 cycles after accept, cycles=4.
- Unsigned, a=0xA000, b=0x3000 → gt=1, done 1 cycle after accept, cycles=1.
- Signed, a=0xFFFF, b=0x0001 → lt=1, cycles=1. The same operands unsigned → gt=1.
- Unsigned, a=0x0012, b=0x0013 → lt=1, cycles=4. Then signed, a=0x8000, b=0x7FFF → lt=1.
- Handshake:
  - start pulsed again while busy with a=0x0000, b=0xFFFF → ignored; the original result stands.
  - start held high in the done cycle with a=0x0001, b=0x0000 → accepted immediately; gt=1 four cycles later.
- Reset:
  - rst asserted asynchronously 2 cycles into a 4-chunk compare → all outputs 0 immediately, no done pulse.
  - After release, a=0x5555, b=0x5555 → eq=1, cycles=4.
